// File: rtl/ins_block_memory.sv
// Instruction-side block memory: 128-bit block reads with a fixed
// busy latency, plus a word-wide preload port that works in any state.
module ins_block_memory #(
  parameter int READ_LATENCY = 4,
  parameter int DEPTH_BLOCKS = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_read,
  input  logic [27:0]  in_address,
  output logic [127:0] out_readdata,
  output logic         out_busywait,
  input  logic         in_load_en,
  input  logic [29:0]  in_load_addr,
  input  logic [31:0]  in_load_data
);

  localparam int AW = $clog2(DEPTH_BLOCKS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [AW-1:0] addr_q;
  logic          addr_en;
  logic          load_rd;
  logic [AW-1:0] ld_blk;
  logic [1:0]    ld_word;
  logic [127:0]  blk_fwd;
  logic          unused_bits;

  logic [31:0] mem [DEPTH_BLOCKS*4];

  assign ld_blk      = in_load_addr[AW+1:2];
  assign ld_word     = in_load_addr[1:0];
  assign unused_bits = ^{in_address[27:AW], in_load_addr[29:AW+2]};

  assign out_busywait = in_read && (state != DONE);
  assign addr_en      = (state == IDLE) && in_read;

  // A preload landing on the block being returned wins over the old word.
  always_comb begin
    blk_fwd = '0;
    for (int w = 0; w < 4; w++) begin
      if (in_load_en && ld_blk == addr_q && ld_word == 2'(w))
        blk_fwd[w*32 +: 32] = in_load_data;
      else
        blk_fwd[w*32 +: 32] = mem[{addr_q, 2'(w)}];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_read) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(READ_LATENCY - 1);
        end
      end
      BUSY: begin
        if (!in_read) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = DONE;
          load_rd   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      out_readdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (addr_en)
        addr_q <= in_address[AW-1:0];
      if (load_rd)
        out_readdata <= blk_fwd;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (in_load_en)
      mem[in_load_addr[AW+1:0]] <= in_load_data;
  end

endmodule

// File: tb/tb_ins_block_memory.sv
// Bench for ins_block_memory: word-array reference model, directed
// corner cases and randomized reads, preloads and aborts.
module tb_ins_block_memory;

  localparam int L = 4;
  localparam int D = 256;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_read = 1'b0;
  logic [27:0]  in_address = '0;
  logic [127:0] out_readdata;
  logic         out_busywait;
  logic         in_load_en = 1'b0;
  logic [29:0]  in_load_addr = '0;
  logic [31:0]  in_load_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [D*4];

  ins_block_memory #(
    .READ_LATENCY(L),
    .DEPTH_BLOCKS(D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_read     (in_read),
    .in_address  (in_address),
    .out_readdata(out_readdata),
    .out_busywait(out_busywait),
    .in_load_en  (in_load_en),
    .in_load_addr(in_load_addr),
    .in_load_data(in_load_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [27:0] a);
    int b;
    b = int'(a) % D;
    return {mem_m[b*4+3], mem_m[b*4+2], mem_m[b*4+1], mem_m[b*4]};
  endfunction

  // Call just after a rising edge.
  task automatic load(input int w, input logic [31:0] d);
    in_load_en   = 1'b1;
    in_load_addr = 30'(w);
    in_load_data = d;
    @(posedge clock);
    mem_m[w % (D*4)] = d;
    #1 in_load_en = 1'b0;
  endtask

  // Call just after a rising edge; returns mid-cycle in the DONE cycle.
  task automatic read_blk(input logic [27:0] a, input string tag);
    int n;
    n = 0;
    in_read    = 1'b1;
    in_address = a;
    @(negedge clock);
    while (out_busywait && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_lat"}, 128'(n), 128'(L + 1));
    chk({tag, "_data"}, out_readdata, blk(a));
  endtask

  task automatic end_read();
    in_read = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] prev;
    logic [27:0]  a;
    int k;

    #2;
    chk("rst_data", out_readdata, 128'h0);
    chk("rst_busy_lo", 128'(out_busywait), 128'h0);
    in_read = 1'b1;
    #1 chk("rst_busy_hi", 128'(out_busywait), 128'h1);
    repeat (2) @(posedge clock);
    #1 chk("rst_hold", out_readdata, 128'h0);
    in_read = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;

    for (int w = 0; w < D*4; w++)
      load(w, $urandom);
    load(20, 32'h00000000);
    load(21, 32'h11111111);
    load(22, 32'h22222222);
    load(23, 32'h33333333);

    read_blk(28'd5, "blk5");
    chk("blk5_const", out_readdata,
        128'h33333333_22222222_11111111_00000000);
    end_read();

    read_blk(28'h0000105, "wrap");
    end_read();

    prev       = out_readdata;
    in_read    = 1'b1;
    in_address = 28'd7;
    repeat (2) @(posedge clock);
    #1 in_read = 1'b0;
    #1 chk("abort_busy", 128'(out_busywait), 128'h0);
    repeat (4) begin
      @(negedge clock);
      chk("abort_hold", out_readdata, prev);
    end
    @(posedge clock);
    #1 read_blk(28'd9, "after_abort");
    end_read();

    read_blk(28'd5, "b2b_first");
    in_address = 28'd6;
    @(posedge clock);
    #1 read_blk(28'd6, "b2b_second");
    end_read();

    in_read    = 1'b1;
    in_address = 28'd10;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1 chk("midrst_data", out_readdata, 128'h0);
    chk("midrst_busy", 128'(out_busywait), 128'h1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    read_blk(28'd10, "post_rst");
    end_read();

    in_read    = 1'b1;
    in_address = 28'd16;
    repeat (L) @(posedge clock);
    #1;
    in_load_en   = 1'b1;
    in_load_addr = 30'h40;
    in_load_data = 32'hDEADBEEF;
    @(posedge clock);
    mem_m[64] = 32'hDEADBEEF;
    #1 in_load_en = 1'b0;
    chk("wf_busy", 128'(out_busywait), 128'h0);
    chk("wf_word0", 128'(out_readdata[31:0]), 128'hDEADBEEF);
    chk("wf_block", out_readdata, blk(28'd16));
    end_read();

    repeat (30) begin
      a = 28'($urandom);
      repeat ($urandom_range(0, 2))
        load(((int'(a) % D) * 4) + int'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        k          = int'($urandom_range(1, L));
        prev       = out_readdata;
        in_read    = 1'b1;
        in_address = a;
        repeat (k) @(posedge clock);
        #1 in_read = 1'b0;
        #1 chk("rnd_abort_busy", 128'(out_busywait), 128'h0);
        @(posedge clock);
        @(negedge clock);
        chk("rnd_abort_hold", out_readdata, prev);
        @(posedge clock);
        #1;
      end else begin
        read_blk(a, "rnd");
        end_read();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ins_block_memory.md
INS_BLOCK_MEMORY -- requirements
Module: ins_block_memory

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 4, giving the number of BUSY cycles per block read (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_BLOCKS, default 256, giving the number of 128-bit blocks stored (power of two).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port in_read, input, 1, the block read request from the instruction cache (its out_MAIN_MEM_READ).
REQ-006 SHALL have port in_address, input, 28, the block address (byte address [31:4]).
REQ-007 SHALL have port out_readdata, output, 128, the block data; word 0 occupies bits [31:0] and word 3 occupies bits [127:96].
REQ-008 SHALL have port out_busywait, output, 1, high while a request is pending and data is not yet valid.
REQ-009 SHALL have port in_load_en, input, 1, the preload write strobe.
REQ-010 SHALL have port in_load_addr, input, 30, the preload word address (byte address [31:2]).
REQ-011 SHALL have port in_load_data, input, 32, the preload word.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, BUSY, DONE.
REQ-013 SHALL, in IDLE with in_read=1 at a rising edge, latch in_address[log2(DEPTH_BLOCKS)-1:0] (upper bits ignored, so the address wraps modulo DEPTH_BLOCKS), load the counter with READ_LATENCY-1, and go to BUSY.
REQ-014 SHALL, in BUSY, decrement the counter at each edge; an edge with counter=0 and in_read=1 loads out_readdata from the latched block and goes to DONE.
REQ-015 SHALL, in BUSY with in_read=0 at an edge, abort to IDLE with out_readdata unchanged.
REQ-016 SHALL ignore in_address changes during BUSY; the latched address is used.
REQ-017 SHALL drive out_busywait combinationally as in_read AND (state != DONE), so busywait is high in the same cycle the read is first raised.
REQ-018 SHALL hold DONE for exactly one cycle, with out_busywait=0 and out_readdata valid, then return to IDLE unconditionally.
REQ-019 SHALL hold out_readdata stable outside the DONE-entry edge; it changes only on that edge.
REQ-020 SHALL treat in_read still high in the IDLE cycle after DONE as a new request per REQ-013 (back-to-back and prefetch reads are supported).
REQ-021 SHALL give a read latency of READ_LATENCY+1 rising edges from the first edge sampling in_read=1 to the DONE cycle.
REQ-022 SHALL, on in_load_en=1 at an edge, write in_load_data into word in_load_addr[1:0] of block in_load_addr[log2(DEPTH_BLOCKS)+1:2], in any state.
REQ-023 SHALL resolve a simultaneous preload to the block being read as write-first: the DONE data includes the new word.

Reset
REQ-024 SHALL, while reset=0, force state to IDLE, counter to 0, and out_readdata to 0, independent of clock.
REQ-025 SHALL drive out_busywait=in_read during reset, because state is IDLE.
REQ-026 SHALL abort any request in flight on a reset assertion mid-BUSY; after release, a held in_read restarts per REQ-013.
REQ-027 SHALL leave memory contents unchanged on reset.

Verification
REQ-028 Preload block 5 = {0x33333333,0x22222222,0x11111111,0x00000000}, L=4, hold in_read with address 5 -> busywait high 5 cycles, then one DONE cycle with out_readdata=0x33333333_22222222_11111111_00000000 and busywait=0.
REQ-029 Address 0x0000105 with DEPTH_BLOCKS=256 -> returns block 5 data (wrap).
REQ-030 Deassert in_read after 2 BUSY cycles -> IDLE, busywait=0, out_readdata unchanged, no DONE pulse.
REQ-031 Keep in_read high through DONE with the address changed to 6 -> second DONE exactly L+1 edges after the DONE cycle, carrying block 6.
REQ-032 Assert reset=0 mid-BUSY -> out_readdata=0 immediately; after release with in_read high, a full L+1 latency before DONE.
REQ-033 Preload word 0x40 (block 16, word 0) = 0xDEADBEEF on the DONE-entry edge of a block 16 read -> DONE data[31:0]=0xDEADBEEF.
